// File: rtl/mips_ctrl_state_pkg.sv
// mips_ctrl_state_pkg: ALU, instruction-type, opcode/funct and exception-cause encodings.
package mips_ctrl_state_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_ADDU = 4'd1, ALU_SUB = 4'd2, ALU_SUBU = 4'd3,
    ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_SLT = 4'd11, ALU_SLTU = 4'd12
  } alu_op_e;
  typedef enum logic [1:0] {IT_R = 2'd0, IT_I = 2'd1, IT_J = 2'd2, IT_B = 2'd3} ins_type_e;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                         OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
                         OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SYSCALL = 6'h0C,
                         FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                         FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
                         FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  localparam logic [4:0] EXC_NONE = 5'd0, EXC_ADEL = 5'd4, EXC_ADES = 5'd5, EXC_IBE = 5'd6,
                         EXC_DBE = 5'd7, EXC_BP = 5'd9, EXC_RI = 5'd10, EXC_CPU = 5'd11,
                         EXC_OV = 5'd12;
endpackage

// File: rtl/exception_unit.sv
// exception_unit: prioritises fault inputs into a halt request, cause code and load strobes.
module exception_unit
  import mips_ctrl_state_pkg::*;
(
  input  logic       rst_b,
  input  logic       IBE,
  input  logic       DBE,
  input  logic       RI,
  input  logic       Ov,
  input  logic       BP,
  input  logic       AdEL_inst,
  input  logic       AdEL_data,
  input  logic       AdES,
  input  logic       CpU,
  output logic       exception_halt,
  output logic       load_ex_regs,
  output logic       load_bva,
  output logic       load_bva_sel,
  output logic [4:0] cause
);
  logic [4:0] win;
  logic       addr_f, data_f;
  always_comb begin
    win = EXC_NONE;
    addr_f = 1'b0;
    data_f = 1'b0;
    if (AdEL_inst) begin win = EXC_ADEL; addr_f = 1'b1; end
    else if (IBE) win = EXC_IBE;
    else if (RI) win = EXC_RI;
    else if (CpU) win = EXC_CPU;
    else if (Ov) win = EXC_OV;
    else if (BP) win = EXC_BP;
    else if (AdEL_data) begin win = EXC_ADEL; addr_f = 1'b1; data_f = 1'b1; end
    else if (AdES) begin win = EXC_ADES; addr_f = 1'b1; data_f = 1'b1; end
    else if (DBE) win = EXC_DBE;
  end
  assign exception_halt = rst_b & |{IBE, DBE, RI, Ov, BP, AdEL_inst, AdEL_data, AdES, CpU};
  assign load_ex_regs = exception_halt;
  assign load_bva = exception_halt & addr_f;
  assign load_bva_sel = rst_b & data_f;
  assign cause = rst_b ? win : EXC_NONE;
endmodule

// File: rtl/mips_decode.sv
// mips_decode: combinational opcode/funct decoder producing datapath control.
module mips_decode
  import mips_ctrl_state_pkg::*;
(
  input  logic [5:0] dcd_op,
  input  logic [5:0] dcd_funct2,
  output logic       ctrl_we,
  output logic       ctrl_Sys,
  output logic       ctrl_RI,
  output logic [3:0] alu__sel,
  output logic       alu__src,
  output logic       mem_to_reg,
  output logic [1:0] ins_type,
  output logic       imm_sign,
  output logic       is_shift,
  output logic [2:0] mem_read_bytes,
  output logic [2:0] mem_write_bytes,
  output logic [3:0] mem_write_en
);
  always_comb begin
    ctrl_we = 1'b0;
    ctrl_Sys = 1'b0;
    ctrl_RI = 1'b0;
    alu__sel = ALU_ADD;
    alu__src = 1'b0;
    mem_to_reg = 1'b0;
    ins_type = IT_R;
    imm_sign = 1'b0;
    is_shift = 1'b0;
    mem_read_bytes = 3'd0;
    mem_write_bytes = 3'd0;
    mem_write_en = 4'd0;
    case (dcd_op)
      OP_SPECIAL: begin
        case (dcd_funct2)
          FN_ADD:     alu__sel = ALU_ADD;
          FN_ADDU:    alu__sel = ALU_ADDU;
          FN_SUB:     alu__sel = ALU_SUB;
          FN_SUBU:    alu__sel = ALU_SUBU;
          FN_AND:     alu__sel = ALU_AND;
          FN_OR:      alu__sel = ALU_OR;
          FN_XOR:     alu__sel = ALU_XOR;
          FN_NOR:     alu__sel = ALU_NOR;
          FN_SLT:     alu__sel = ALU_SLT;
          FN_SLTU:    alu__sel = ALU_SLTU;
          FN_SLL:     begin alu__sel = ALU_SLL; is_shift = 1'b1; end
          FN_SRL:     begin alu__sel = ALU_SRL; is_shift = 1'b1; end
          FN_SRA:     begin alu__sel = ALU_SRA; is_shift = 1'b1; end
          FN_SYSCALL: ctrl_Sys = 1'b1;
          default:    ctrl_RI = 1'b1;
        endcase
        ctrl_we = !(ctrl_Sys || ctrl_RI);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        ins_type = IT_I;
        ctrl_we = 1'b1;
        alu__src = 1'b1;
        imm_sign = !dcd_op[2];
        case (dcd_op)
          OP_ADDIU: alu__sel = ALU_ADDU;
          OP_SLTI:  alu__sel = ALU_SLT;
          OP_SLTIU: alu__sel = ALU_SLTU;
          OP_ANDI:  alu__sel = ALU_AND;
          OP_ORI:   alu__sel = ALU_OR;
          OP_XORI:  alu__sel = ALU_XOR;
          default:  alu__sel = ALU_ADD;
        endcase
      end
      OP_LB, OP_LH, OP_LW: begin
        ins_type = IT_I;
        ctrl_we = 1'b1;
        mem_to_reg = 1'b1;
        alu__src = 1'b1;
        imm_sign = 1'b1;
        mem_read_bytes = dcd_op == OP_LB ? 3'd1 : dcd_op == OP_LH ? 3'd2 : 3'd4;
      end
      OP_SB, OP_SH, OP_SW: begin
        ins_type = IT_I;
        alu__src = 1'b1;
        imm_sign = 1'b1;
        mem_write_bytes = dcd_op == OP_SB ? 3'd1 : dcd_op == OP_SH ? 3'd2 : 3'd4;
        mem_write_en = dcd_op == OP_SB ? 4'b0001 : dcd_op == OP_SH ? 4'b0011 : 4'b1111;
      end
      OP_BEQ, OP_BNE: begin
        ins_type = IT_B;
        alu__sel = ALU_SUB;
      end
      OP_J, OP_JAL: begin
        ins_type = IT_J;
        ctrl_we = dcd_op == OP_JAL;
      end
      default: ctrl_RI = 1'b1;
    endcase
    if (ctrl_RI) begin
      ctrl_we = 1'b0;
      mem_write_en = 4'd0;
    end
  end
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 register file, two combinational read ports, r0 hardwired to zero.
module regfile (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [4:0]  rs_num,
  input  logic [4:0]  rt_num,
  input  logic [4:0]  rd_num,
  input  logic [31:0] rd_data,
  input  logic        rd_we,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);
  logic [31:0] regs_q [32];
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) regs_q <= '{default: '0};
    else if (rd_we && rd_num != 5'd0) regs_q[rd_num] <= rd_data;
  end
  assign rs_data = rs_num == 5'd0 ? 32'd0 : regs_q[rs_num];
  assign rt_data = rt_num == 5'd0 ? 32'd0 : regs_q[rt_num];
endmodule

// File: rtl/mips_ctrl_state.sv
// mips_ctrl_state: wrapper tying decoder, register file and exception unit together.
module mips_ctrl_state (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [5:0]  dcd_op,
  input  logic [5:0]  dcd_funct2,
  output logic        ctrl_we,
  output logic        ctrl_Sys,
  output logic        ctrl_RI,
  output logic [3:0]  alu__sel,
  output logic        alu__src,
  output logic        mem_to_reg,
  output logic [1:0]  ins_type,
  output logic        imm_sign,
  output logic        is_shift,
  output logic [2:0]  mem_read_bytes,
  output logic [2:0]  mem_write_bytes,
  output logic [3:0]  mem_write_en,
  input  logic [4:0]  rs_num,
  input  logic [4:0]  rt_num,
  input  logic [4:0]  rd_num,
  input  logic [31:0] rd_data,
  input  logic        rd_we,
  input  logic        halted,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic [31:0] pc,
  input  logic        IBE,
  input  logic        DBE,
  input  logic        RI,
  input  logic        Ov,
  input  logic        BP,
  input  logic        AdEL_inst,
  input  logic        AdEL_data,
  input  logic        AdES,
  input  logic        CpU,
  output logic        exception_halt,
  output logic        load_ex_regs,
  output logic        load_bva,
  output logic        load_bva_sel,
  output logic [4:0]  cause
);
  // halted/pc only feed the simulation-side register dump, which lives outside synthesis
  logic unused_dump;
  assign unused_dump = ^{halted, pc};
  mips_decode u_dec (
    .dcd_op(dcd_op), .dcd_funct2(dcd_funct2), .ctrl_we(ctrl_we), .ctrl_Sys(ctrl_Sys),
    .ctrl_RI(ctrl_RI), .alu__sel(alu__sel), .alu__src(alu__src), .mem_to_reg(mem_to_reg),
    .ins_type(ins_type), .imm_sign(imm_sign), .is_shift(is_shift),
    .mem_read_bytes(mem_read_bytes), .mem_write_bytes(mem_write_bytes),
    .mem_write_en(mem_write_en)
  );
  regfile u_rf (
    .clk(clk), .rst_b(rst_b), .rs_num(rs_num), .rt_num(rt_num), .rd_num(rd_num),
    .rd_data(rd_data), .rd_we(rd_we), .rs_data(rs_data), .rt_data(rt_data)
  );
  exception_unit u_exc (
    .rst_b(rst_b), .IBE(IBE), .DBE(DBE), .RI(RI), .Ov(Ov), .BP(BP), .AdEL_inst(AdEL_inst),
    .AdEL_data(AdEL_data), .AdES(AdES), .CpU(CpU), .exception_halt(exception_halt),
    .load_ex_regs(load_ex_regs), .load_bva(load_bva), .load_bva_sel(load_bva_sel),
    .cause(cause)
  );
endmodule

// File: tb/tb_mips_ctrl_state.sv
// tb_mips_ctrl_state: random and directed checks of decoder, register file and exceptions
// against table-driven reference models.
module tb_mips_ctrl_state;
  logic        clk = 1'b0, rst_b = 1'b0;
  logic [5:0]  dcd_op = '0, dcd_funct2 = '0;
  logic        ctrl_we, ctrl_Sys, ctrl_RI, alu__src, mem_to_reg, imm_sign, is_shift;
  logic [3:0]  alu__sel, mem_write_en;
  logic [1:0]  ins_type;
  logic [2:0]  mem_read_bytes, mem_write_bytes;
  logic [4:0]  rs_num = '0, rt_num = '0, rd_num = '0;
  logic [31:0] rd_data = '0, rs_data, rt_data, pc = '0;
  logic        rd_we = 1'b0, halted = 1'b0;
  logic [8:0]  flt = '0;
  logic        IBE, DBE, RI, Ov, BP, AdEL_inst, AdEL_data, AdES, CpU;
  logic        exception_halt, load_ex_regs, load_bva, load_bva_sel;
  logic [4:0]  cause;
  assign {AdEL_inst, IBE, RI, CpU, Ov, BP, AdEL_data, AdES, DBE} = flt;
  mips_ctrl_state dut (
    .clk(clk), .rst_b(rst_b), .dcd_op(dcd_op), .dcd_funct2(dcd_funct2), .ctrl_we(ctrl_we),
    .ctrl_Sys(ctrl_Sys), .ctrl_RI(ctrl_RI), .alu__sel(alu__sel), .alu__src(alu__src),
    .mem_to_reg(mem_to_reg), .ins_type(ins_type), .imm_sign(imm_sign), .is_shift(is_shift),
    .mem_read_bytes(mem_read_bytes), .mem_write_bytes(mem_write_bytes),
    .mem_write_en(mem_write_en), .rs_num(rs_num), .rt_num(rt_num), .rd_num(rd_num),
    .rd_data(rd_data), .rd_we(rd_we), .halted(halted), .rs_data(rs_data), .rt_data(rt_data),
    .pc(pc), .IBE(IBE), .DBE(DBE), .RI(RI), .Ov(Ov), .BP(BP), .AdEL_inst(AdEL_inst),
    .AdEL_data(AdEL_data), .AdES(AdES), .CpU(CpU), .exception_halt(exception_halt),
    .load_ex_regs(load_ex_regs), .load_bva(load_bva), .load_bva_sel(load_bva_sel),
    .cause(cause)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  logic [31:0] mdl [32];
  logic [22:0] op_tbl [64];
  logic [22:0] fn_tbl [64];
  // fault priority, highest first, matching flt bit 8 down to 0
  int exc_cause [9] = '{4, 6, 10, 11, 12, 9, 4, 5, 7};
  bit exc_addr [9] = '{1, 0, 0, 0, 0, 0, 1, 1, 0};
  bit exc_data [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [22:0] pk(input bit we, sys, ri, input int sel, input bit src, m2r,
                                     input int typ, input bit sgn, sh, input int rb, wb, wen);
    return {we, sys, ri, 4'(sel), src, m2r, 2'(typ), sgn, sh, 3'(rb), 3'(wb), 4'(wen)};
  endfunction
  task automatic build_tables();
    int r_fn [10] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
    int r_alu [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 11, 12};
    int i_alu [7] = '{0, 1, 11, 12, 4, 5, 6};
    int bytes [3] = '{1, 2, 4};
    int ld_op [3] = '{'h20, 'h21, 'h23};
    int st_op [3] = '{'h28, 'h29, 'h2B};
    for (int i = 0; i < 64; i++) begin
      op_tbl[i] = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      fn_tbl[i] = op_tbl[i];
    end
    for (int i = 0; i < 10; i++) fn_tbl[r_fn[i]] = pk(1, 0, 0, r_alu[i], 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) fn_tbl[i == 0 ? 0 : i + 1] = pk(1, 0, 0, 8 + i, 0, 0, 0, 0, 1, 0, 0, 0);
    fn_tbl['h0C] = pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) op_tbl[8 + i] = pk(1, 0, 0, i_alu[i], 1, 0, 1, i < 4, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      op_tbl[ld_op[i]] = pk(1, 0, 0, 0, 1, 1, 1, 1, 0, bytes[i], 0, 0);
      op_tbl[st_op[i]] = pk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, bytes[i], (1 << bytes[i]) - 1);
    end
    op_tbl['h04] = pk(0, 0, 0, 2, 0, 0, 3, 0, 0, 0, 0, 0);
    op_tbl['h05] = op_tbl['h04];
    op_tbl['h02] = pk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    op_tbl['h03] = pk(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
  endtask
  task automatic check_now();
    logic [22:0] dexp;
    int w;
    dexp = dcd_op == 6'h00 ? fn_tbl[dcd_funct2] : op_tbl[dcd_op];
    chk("decode", {9'd0, ctrl_we, ctrl_Sys, ctrl_RI, alu__sel, alu__src, mem_to_reg, ins_type,
                   imm_sign, is_shift, mem_read_bytes, mem_write_bytes, mem_write_en}, {9'd0, dexp});
    w = -1;
    for (int i = 0; i < 9; i++) if (w < 0 && flt[8 - i]) w = i;
    chk("exc_halt", {31'd0, exception_halt}, {31'd0, rst_b && w >= 0});
    chk("ld_ex_regs", {31'd0, load_ex_regs}, {31'd0, rst_b && w >= 0});
    chk("cause", {27'd0, cause}, rst_b && w >= 0 ? exc_cause[w] : 0);
    chk("load_bva", {31'd0, load_bva}, {31'd0, rst_b && w >= 0 && exc_addr[w]});
    if (rst_b && w >= 0 && exc_addr[w]) chk("bva_sel", {31'd0, load_bva_sel}, {31'd0, exc_data[w]});
    chk("rs_data", rs_data, rs_num == 0 ? 32'd0 : mdl[rs_num]);
    chk("rt_data", rt_data, rt_num == 0 ? 32'd0 : mdl[rt_num]);
  endtask
  task automatic cycle(input logic [5:0] op, fn, input logic [8:0] f, input logic [4:0] rs, rt,
                       rd, input logic [31:0] d, input logic we);
    dcd_op = op; dcd_funct2 = fn; flt = f;
    rs_num = rs; rt_num = rt; rd_num = rd; rd_data = d; rd_we = we;
    #1 check_now();
    @(posedge clk);
    if (we && rd != 0) mdl[rd] = d;
    @(negedge clk);
  endtask
  task automatic rand_cycles(input int n);
    logic [5:0] ops [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                             6'h0C, 6'h0D, 6'h0E, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B};
    logic [5:0] fns [14] = '{6'h00, 6'h02, 6'h03, 6'h0C, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                             6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    for (int k = 0; k < n; k++)
      cycle($urandom_range(0, 1) ? ops[$urandom_range(0, 17)] : 6'($urandom),
            $urandom_range(0, 1) ? fns[$urandom_range(0, 13)] : 6'($urandom),
            9'($urandom & $urandom & $urandom), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, 1'($urandom));
  endtask
  initial begin
    build_tables();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    flt = '1;
    #1 chk("rst_halt", {31'd0, exception_halt}, 32'd0);
    chk("rst_cause", {27'd0, cause}, 32'd0);
    @(negedge clk) rst_b = 1'b1;
    for (int i = 0; i < 32; i++) cycle(6'h00, 6'h20, 9'd0, 5'(i), 5'(31 - i), 5'd0, 32'd0, 1'b0);
    cycle(6'h23, 6'h00, 9'd0, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1);
    cycle(6'h2B, 6'h00, 9'd0, 5'd5, 5'd5, 5'd0, 32'h12345678, 1'b1);
    cycle(6'h00, 6'h03, 9'd0, 5'd0, 5'd5, 5'd0, 32'd0, 1'b0);
    cycle(6'h00, 6'h0C, 9'b011000000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    cycle(6'h3F, 6'h00, 9'b000000010, 5'd5, 5'd0, 5'd0, 32'd0, 1'b0);
    cycle(6'h00, 6'h3F, 9'b000000111, 5'd5, 5'd0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(6'h04, 6'h00, 9'(1 << i), 5'd5, 5'd0, 5'd0, 32'd0, 1'b0);
    rand_cycles(400);
    #3 rst_b = 1'b0;
    flt = '1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int i = 0; i < 32; i++) begin
      rs_num = 5'(i); rt_num = 5'(31 - i);
      #0.1 check_now();
    end
    @(negedge clk) rst_b = 1'b1;
    rand_cycles(200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mips_ctrl_state.md
# mips_ctrl_state

Control-and-state block for the single-cycle MIPS core: opcode/funct decoder, 32×32 register file, and exception detector. The decoder is purely combinational. The register file is the core's only architectural data state. The exception detector turns fault inputs into a halt request, a cause code and exception-register load strobes.

## Interface
- Parameters: none.
- clk  in  1  system clock, rising-edge.
- rst_b  in  1  asynchronous, active-low reset.
- dcd_op  in  6  opcode, inst[31:26].
- dcd_funct2  in  6  funct, inst[5:0].
- ctrl_we  out  1  register-file write enable.
- ctrl_Sys  out  1  SYSCALL decoded.
- ctrl_RI  out  1  reserved/unsupported instruction.
- alu__sel  out  4  ALU operation code.
- alu__src  out  1  ALU op2 from immediate (1) or rt (0).
- mem_to_reg  out  1  instruction is a load.
- ins_type  out  2  R=0, I=1, J=2, B=3.
- imm_sign  out  1  sign-extend (1) or zero-extend (0) the immediate.
- is_shift  out  1  SLL/SRL/SRA.
- mem_read_bytes  out  3  load width in bytes.
- mem_write_bytes  out  3  store width in bytes.
- mem_write_en  out  4  store byte mask.
- rs_num, rt_num, rd_num  in  5  read and write register indices.
- rd_data  in  32  write data.
- rd_we  in  1  write strobe.
- halted  in  1  processor halted; triggers register dump.
- rs_data, rt_data  out  32  read data.
- pc  in  32  current PC (for the dump only).
- IBE, DBE, RI, Ov, BP, AdEL_inst, AdEL_data, AdES, CpU  in  1 each  fault inputs.
- exception_halt  out  1  halt request.
- load_ex_regs  out  1  load EPC/Cause.
- load_bva  out  1  load BadVAddr.
- load_bva_sel  out  1  0 = instruction address fault, 1 = data address fault.
- cause  out  5  exception code.

## Operation
- **Decoder defaults:** every output is 0 and alu__sel = ADD.
- **op 0x00 (R-type):** ins_type R, ctrl_we = 1, alu__src = 0.
  - funct 20/21/22/23/24/25/26/27/2A/2B → ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU.
  - funct 00/02/03 → SLL/SRL/SRA with is_shift = 1.
  - funct 0C → ctrl_Sys = 1, ctrl_we = 0.
  - Any other funct → ctrl_RI = 1, ctrl_we = 0.
- **ALU immediates (ins_type I, ctrl_we = 1, alu__src = 1):**
  - 08 ADD, 09 ADDU, 0A SLT, 0B SLTU, all with imm_sign = 1.
  - 0C AND, 0D OR, 0E XOR, all with imm_sign = 0.
- **Loads (ins_type I, ctrl_we = 1, mem_to_reg = 1, alu__src = 1, imm_sign = 1, alu ADD):**
  - 20 LB → mem_read_bytes 1.
  - 21 LH → mem_read_bytes 2.
  - 23 LW → mem_read_bytes 4.
- **Stores (ins_type I, ctrl_we = 0, alu__src = 1, imm_sign = 1, alu ADD):**
  - 28 SB → mem_write_en 0001, mem_write_bytes 1.
  - 29 SH → mem_write_en 0011, mem_write_bytes 2.
  - 2B SW → mem_write_en 1111, mem_write_bytes 4.
- **Branches:** 04 BEQ and 05 BNE → ins_type B, alu SUB, alu__src = 0, ctrl_we = 0.
- **Jumps:** 02 J → ins_type J, ctrl_we = 0. 03 JAL → ins_type J, ctrl_we = 1.
- **Unknown opcode:** ctrl_RI = 1. ctrl_we and mem_write_en are forced to 0 on any RI.
- **Register file reads:** combinational; register 0 always reads 0.
- **Register file writes:** occur only when rd_we = 1 and rd_num ≠ 0.
- **Register dump:** on the rising edge of halted, display pc and all 32 registers. This is simulation-only and not synthesized.
- **Exception priority:** first active input wins.
  - AdEL_inst → cause 4, load_bva_sel 0.
  - IBE → cause 6.
  - RI → cause 10.
  - CpU → cause 11.
  - Ov → cause 12.
  - BP → cause 9.
  - AdEL_data → cause 4, load_bva_sel 1.
  - AdES → cause 5, load_bva_sel 1.
  - DBE → cause 7.
  - None active → cause 0.
- **Exception outputs:**
  - exception_halt = load_ex_regs = rst_b AND (any fault input).
  - load_bva = exception_halt AND the winner is an address fault (AdEL_inst, AdEL_data or AdES).

## Timing
- Decoder and exception outputs are combinational, 0-cycle.
- Register write commits at the rising clk edge.
- Read during a same-cycle write to the same register returns the old value; there is no bypass.
- Asynchronous reset clears all 32 registers to 0. While rst_b = 0, exception outputs are 0 and cause is 0.
- The block holds no state besides the registers. Halt latching is external.
- Multiple simultaneous faults resolve by priority alone; only one cause is reported.

## Structure
- Shared package holds:
  - ALU codes: ADD 0, ADDU 1, SUB 2, SUBU 3, AND 4, OR 5, XOR 6, NOR 7, SLL 8, SRL 9, SRA 10, SLT 11, SLTU 12.
  - ins_type codes.
  - Opcode and funct constants.
  - Exception cause codes.
- Three sub-modules under a thin wrapper: mips_decode, regfile, exception_unit.

## Test plan
- Reset with rst_b = 0 mid-run → all registers read 0 and exception_halt = 0.
- Write 0xDEADBEEF to r5 and read rs_num = 5 in the same cycle → old value. Read the next cycle → 0xDEADBEEF.
- Write to r0 → r0 reads 0.
- op 23 (LW) → ctrl_we 1, mem_to_reg 1, ins_type 1, mem_read_bytes 4, alu ADD.
- op 2B (SW) → mem_write_en 1111, ctrl_we 0.
- op 00 with funct 03 → SRA, is_shift 1, ins_type 0.
- op 00 with funct 0C → ctrl_Sys 1.
- op 3F → ctrl_RI 1, ctrl_we 0.
- IBE = 1 and RI = 1 together → cause 6, exception_halt 1, load_bva 0.
- AdES = 1 alone → cause 5, load_bva 1, load_bva_sel 1.
